// File: rtl/weight_loader_param_1.sv
// Weight RAM loader: packs a serial word stream into pairs and writes them
// two per cycle (even address on port A, odd on port B) in group order.
module weight_loader_param_1 #(
    parameter int unsigned NUM_ONEMULT         = 4,
    parameter int unsigned NUM_ONE_PIXEL_CYCLE = 13,
    parameter int unsigned WEIGHT_ADDR_WIDTH   = 10,
    parameter int unsigned DATA_WIDTH          = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         s_valid,
    input  logic [DATA_WIDTH-1:0]        s_data,
    output logic                         s_ready,
    output logic                         wea,
    output logic                         web,
    output logic [WEIGHT_ADDR_WIDTH-1:0] addra,
    output logic [WEIGHT_ADDR_WIDTH-1:0] addrb,
    output logic [DATA_WIDTH-1:0]        dina,
    output logic [DATA_WIDTH-1:0]        dinb,
    output logic                         grp_done,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned PairW = (NUM_ONE_PIXEL_CYCLE > 1) ? $clog2(NUM_ONE_PIXEL_CYCLE) : 1;
    localparam int unsigned GrpW  = (NUM_ONEMULT > 1) ? $clog2(NUM_ONEMULT) : 1;

    localparam logic [PairW-1:0] PairLast = PairW'(NUM_ONE_PIXEL_CYCLE - 1);
    localparam logic [GrpW-1:0]  GrpLast  = GrpW'(NUM_ONEMULT - 1);
    localparam logic [PairW-1:0] PairOne  = PairW'(1);
    localparam logic [GrpW-1:0]  GrpOne   = GrpW'(1);

    localparam logic [WEIGHT_ADDR_WIDTH-1:0] AddrOne = WEIGHT_ADDR_WIDTH'(1);
    localparam logic [WEIGHT_ADDR_WIDTH-1:0] AddrTwo = WEIGHT_ADDR_WIDTH'(2);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e                         state_q, state_d;
    logic                           phase_q, phase_d;
    logic [DATA_WIDTH-1:0]          hold_q, hold_d;
    logic [PairW-1:0]               pair_q, pair_d;
    logic [GrpW-1:0]                grp_q, grp_d;
    // Running even address of the next pair; replaces g*NPC*2 + 2k.
    logic [WEIGHT_ADDR_WIDTH-1:0]   waddr_q, waddr_d;

    logic                           we_q, we_d;
    logic [WEIGHT_ADDR_WIDTH-1:0]   addra_q, addra_d;
    logic [WEIGHT_ADDR_WIDTH-1:0]   addrb_q, addrb_d;
    logic [DATA_WIDTH-1:0]          dina_q, dina_d;
    logic [DATA_WIDTH-1:0]          dinb_q, dinb_d;
    logic                           grp_done_q, grp_done_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;

    logic accept;

    assign accept = s_valid && (state_q == StLoad);

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        hold_d     = hold_q;
        pair_d     = pair_q;
        grp_d      = grp_q;
        waddr_d    = waddr_q;
        we_d       = 1'b0;
        addra_d    = addra_q;
        addrb_d    = addrb_q;
        dina_d     = dina_q;
        dinb_d     = dinb_q;
        grp_done_d = 1'b0;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StLoad;
                    phase_d = 1'b0;
                    hold_d  = '0;
                    pair_d  = '0;
                    grp_d   = '0;
                    waddr_d = '0;
                end
            end
            StLoad: begin
                if (accept) begin
                    if (!phase_q) begin
                        hold_d  = s_data;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        we_d    = 1'b1;
                        addra_d = waddr_q;
                        addrb_d = waddr_q + AddrOne;
                        dina_d  = hold_q;
                        dinb_d  = s_data;
                        waddr_d = waddr_q + AddrTwo;
                        if (pair_q == PairLast) begin
                            grp_done_d = 1'b1;
                            pair_d     = '0;
                            grp_d      = grp_q + GrpOne;
                            if (grp_q == GrpLast) begin
                                state_d = StDone;
                            end
                        end else begin
                            pair_d = pair_q + PairOne;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StLoad);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            phase_q    <= 1'b0;
            hold_q     <= '0;
            pair_q     <= '0;
            grp_q      <= '0;
            waddr_q    <= '0;
            we_q       <= 1'b0;
            addra_q    <= '0;
            addrb_q    <= '0;
            dina_q     <= '0;
            dinb_q     <= '0;
            grp_done_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            hold_q     <= hold_d;
            pair_q     <= pair_d;
            grp_q      <= grp_d;
            waddr_q    <= waddr_d;
            we_q       <= we_d;
            addra_q    <= addra_d;
            addrb_q    <= addrb_d;
            dina_q     <= dina_d;
            dinb_q     <= dinb_d;
            grp_done_q <= grp_done_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // busy_q is a flop of (next state == LOAD), i.e. it equals state==LOAD.
    assign s_ready  = busy_q;
    assign wea      = we_q;
    assign web      = we_q;
    assign addra    = addra_q;
    assign addrb    = addrb_q;
    assign dina     = dina_q;
    assign dinb     = dinb_q;
    assign grp_done = grp_done_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_weight_loader_param_1.sv
// Scoreboard bench for weight_loader_param_1: default-size instance driven with
// patterned and random streams, plus a 1x1 instance for the degenerate case.
module tb_weight_loader_param_1;

    localparam int NOM   = 4;
    localparam int NPC   = 13;
    localparam int AW    = 10;
    localparam int DW    = 16;
    localparam int WORDS = NOM * NPC * 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          wea, web;
    logic [AW-1:0] addra, addrb;
    logic [DW-1:0] dina, dinb;
    logic          grp_done, busy, done;

    logic          sm_start, sm_s_valid, sm_s_ready;
    logic [DW-1:0] sm_s_data, sm_dina, sm_dinb;
    logic          sm_wea, sm_web, sm_grp_done, sm_busy, sm_done;
    logic [0:0]    sm_addra, sm_addrb;

    always #5 clk = ~clk;

    weight_loader_param_1 #(
        .NUM_ONEMULT(NOM), .NUM_ONE_PIXEL_CYCLE(NPC), .WEIGHT_ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) u_dut (
        .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .wea(wea), .web(web), .addra(addra), .addrb(addrb),
        .dina(dina), .dinb(dinb), .grp_done(grp_done), .busy(busy), .done(done)
    );

    weight_loader_param_1 #(
        .NUM_ONEMULT(1), .NUM_ONE_PIXEL_CYCLE(1), .WEIGHT_ADDR_WIDTH(1), .DATA_WIDTH(DW)
    ) u_small (
        .clk(clk), .reset(reset), .start(sm_start), .s_valid(sm_s_valid), .s_data(sm_s_data),
        .s_ready(sm_s_ready), .wea(sm_wea), .web(sm_web), .addra(sm_addra), .addrb(sm_addrb),
        .dina(sm_dina), .dinb(sm_dinb), .grp_done(sm_grp_done), .busy(sm_busy),
        .done(sm_done)
    );

    typedef struct {
        int          addra;
        int          dina;
        int          dinb;
        bit          grp_done;
        bit          done;
    } exp_t;

    exp_t          exp_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            wr_cnt  = 0;
    int            word_idx = 0;
    logic [DW-1:0] prev_word;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference: word w of a load; odd w closes pair p = w/2 of group p/NPC.
    task automatic model_accept(input logic [DW-1:0] d);
        exp_t e;
        int   p, g, k;
        if (word_idx % 2 == 1) begin
            p          = word_idx / 2;
            g          = p / NPC;
            k          = p % NPC;
            e.addra    = g * NPC * 2 + 2 * k;
            e.dina     = int'(prev_word);
            e.dinb     = int'(d);
            e.grp_done = (k == NPC - 1);
            e.done     = (p == NOM * NPC - 1);
            exp_q.push_back(e);
        end else begin
            prev_word = d;
        end
        word_idx++;
    endtask

    always @(negedge clk) begin
        if (!reset && (wea || web)) begin
            exp_t e;
            check("we_pair", 64'(web), 64'(wea));
            check("write_expected", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                wr_cnt++;
                check("addra", 64'(addra), 64'(e.addra));
                check("addrb", 64'(addrb), 64'(e.addra + 1));
                check("dina", 64'(dina), 64'(e.dina));
                check("dinb", 64'(dinb), 64'(e.dinb));
                check("grp_done", 64'(grp_done), 64'(e.grp_done));
                check("done_at_write", 64'(done), 64'(e.done));
            end
        end
    end

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [DW-1:0] d);
        int  budget;
        bit  ok;
        s_valid = 1'b1;
        s_data  = d;
        budget  = 0;
        ok      = 1'b0;
        while (!ok && budget < 200) begin
            @(negedge clk);
            if (s_ready) begin
                model_accept(d);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
            budget++;
        end
        if (!ok) check("s_ready_timeout", 64'(0), 64'(1));
    endtask

    task automatic do_start;
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        word_idx = 0;
        wr_cnt   = 0;
        check("start_busy", 64'(busy), 64'(1));
        check("start_s_ready", 64'(s_ready), 64'(1));
        check("start_done_drop", 64'(done), 64'(0));
    endtask

    // mode 0: continuous; 1: fixed stall pattern; 2: random data and stalls;
    // 3: continuous with a start pulse after 10 words.
    task automatic run_load(input int mode, input int base);
        logic [DW-1:0] d;
        do_start();
        for (int i = 0; i < WORDS; i++) begin
            d = (mode == 2) ? DW'($urandom) : DW'(base + i);
            send_word(d);
            if (mode == 1 && ((i % 2) == 1 || ((i + 1) % 5) == 0)) idle(3);
            if (mode == 2 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            if (mode == 3 && i == 9) begin
                s_valid = 1'b0;
                start   = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
                check("mid_start_busy", 64'(busy), 64'(1));
            end
        end
        idle(3);
        check("load_writes", 64'(wr_cnt), 64'(WORDS / 2));
        check("load_queue_empty", 64'(exp_q.size()), 64'(0));
        check("load_done", 64'(done), 64'(1));
        check("load_busy", 64'(busy), 64'(0));
        check("load_s_ready", 64'(s_ready), 64'(0));
    endtask

    task automatic check_all_zero(input string name);
        check(name, 64'({s_ready, wea, web, addra, addrb, dina, dinb, grp_done, busy, done}),
              64'(0));
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        sm_start   = 1'b0;
        sm_s_valid = 1'b0;
        sm_s_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_outputs");
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("idle_after_reset");

        run_load(0, 0);
        run_load(1, 0);
        run_load(3, 0);

        // Reset with half a pair held: nothing must be written.
        do_start();
        for (int i = 0; i < 7; i++) send_word(DW'(i + 500));
        s_valid = 1'b0;
        reset   = 1'b1;
        #1;
        check_all_zero("midload_reset");
        check("midload_queue", 64'(exp_q.size()), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("post_reset_idle");

        run_load(2, 0);
        run_load(0, 1000);

        // Degenerate 1x1 configuration.
        sm_start = 1'b1;
        @(posedge clk);
        #1;
        sm_start = 1'b0;
        check("sm_s_ready", 64'(sm_s_ready), 64'(1));
        sm_s_valid = 1'b1;
        sm_s_data  = 16'hA5A5;
        @(posedge clk);
        #1;
        check("sm_no_early_write", 64'(sm_wea), 64'(0));
        sm_s_data = 16'h5A5A;
        @(posedge clk);
        #1;
        sm_s_valid = 1'b0;
        check("sm_we", 64'({sm_wea, sm_web}), 64'(2'b11));
        check("sm_addr", 64'({sm_addra, sm_addrb}), 64'(2'b01));
        check("sm_data", 64'({sm_dina, sm_dinb}), 64'(32'hA5A5_5A5A));
        check("sm_grp_done", 64'(sm_grp_done), 64'(1));
        check("sm_done", 64'(sm_done), 64'(1));
        check("sm_ready_low", 64'({sm_s_ready, sm_busy}), 64'(0));
        @(posedge clk);
        #1;
        check("sm_after", 64'({sm_wea, sm_grp_done, sm_done}), 64'(3'b001));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/weight_loader_param_1.md
# weight_loader_param_1

Fills the dual-port weight RAM before a convolution layer runs. It accepts a serial stream of weight words and writes them two per cycle, even address on port A and odd address on port B. The layout matches the one the weight read-address generator walks: NUM_ONEMULT groups, each of NUM_ONE_PIXEL_CYCLE*2 contiguous words, with group g based at g*NUM_ONE_PIXEL_CYCLE*2. It sits between the external weight-load interface and the write side of the weight BRAM.

## Interface
- NUM_ONEMULT, 4: output-feature-map groups held in the RAM (≥1)
- NUM_ONE_PIXEL_CYCLE, 13: word pairs per group (≥1)
- WEIGHT_ADDR_WIDTH, 10: RAM address width; must hold NUM_ONEMULT*NUM_ONE_PIXEL_CYCLE*2-1
- DATA_WIDTH, 16: weight word width
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  load request, sampled in IDLE/DONE only
- s_valid  in  1  stream word valid
- s_data  in  DATA_WIDTH  stream weight word
- s_ready  out  1  stream ready; beat accepted when s_valid && s_ready
- wea, web  out  1 each  RAM write enables (always asserted together)
- addra, addrb  out  WEIGHT_ADDR_WIDTH each  write addresses (addrb = addra+1 whenever written)
- dina, dinb  out  DATA_WIDTH each  write data
- grp_done  out  1  one-cycle pulse with the write of each group's last pair
- busy  out  1  high in LOAD
- done  out  1  high in DONE

## Operation
- FSM states: IDLE, LOAD, DONE.
  - IDLE: start=1 → LOAD. The word, pair and group counters and the phase bit are cleared.
  - LOAD: s_ready=1. Each accepted beat toggles the phase bit.
    - Phase 0: s_data is latched into hold; no write.
    - Phase 1: a write of {hold, s_data} is registered for the next cycle.
  - The final pair (pair NUM_ONE_PIXEL_CYCLE-1 of group NUM_ONEMULT-1) accepted → DONE.
  - DONE: done=1. start=1 → LOAD again, with counters cleared.
- Address of a write for group g, pair k: addra = g*NUM_ONE_PIXEL_CYCLE*2 + 2k, addrb = addra+1.
  - Implemented as a running linear pair address; no multiplier is required.
  - The group counter is used for grp_done only.
- Pair counter wraps from NUM_ONE_PIXEL_CYCLE-1 to 0 and increments the group counter.
- Total words accepted per load = NUM_ONEMULT*NUM_ONE_PIXEL_CYCLE*2. Beats beyond that are not accepted (s_ready=0).
- start while in LOAD is ignored.
- s_valid=0 in LOAD stalls the load: counters, hold and phase are unchanged. A stall may occur in either phase.

## Timing
- Reset values: s_ready=0, wea=web=0, addra=addrb=0, dina=dinb=0, grp_done=0, busy=0, done=0; state IDLE; hold, phase and counters 0.
- start sampled at edge t → busy=1 and s_ready=1 from t+1.
- Second word of a pair accepted at edge t → wea=web=1 and addresses/data valid during cycle t+1 (one-cycle latency). Enables are high for exactly one cycle per pair.
- Back-to-back acceptance gives one RAM write every 2 cycles.
- grp_done is coincident with the write cycle of pair NUM_ONE_PIXEL_CYCLE-1 of every group.
- Final pair accepted at edge t:
  - s_ready=0 and busy=0 from t+1.
  - Final write and done=1 during t+1.
  - done stays high until start is accepted.
- Reset mid-load: everything returns to reset values immediately. A half-filled hold word is discarded and no partial write is issued. A write that is pending for the next cycle is cancelled.
- The write-enable, address, data, grp_done, busy and done outputs are all registered. s_ready is registered too, equal to (state==LOAD).

## Test plan
- Defaults, continuous s_valid, words 0..103: 52 writes, each with wea=web=1. Write n has addra=2n, dina=2n, addrb=2n+1, dinb=2n+1. grp_done on writes 12, 25, 38, 51. done=1 one cycle after the 104th beat.
- Same stream with s_valid deasserted for 3 cycles after every odd word and after every 5th word: identical write sequence and contents, with only timing shifted. No write occurs during stalls.
- Pulse start mid-LOAD after 10 words: ignored. Counters continue and the write at pair 5 has addra=10.
- Assert reset after 7 words (hold full, phase 1): all outputs 0 and no write. A fresh start then writes pair 0 with addra=0 and the new data.
- After done, pulse start and stream words 1000..1103: done drops, and the first write is addra=0, dina=1000, dinb=1001.
- Set NUM_ONEMULT=1, NUM_ONE_PIXEL_CYCLE=1: two words produce a single write at addra=0/addrb=1. grp_done and done follow in the same cycle, and s_ready=0 afterwards.
